// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 block packing path.
//   WORD_W    : width of one word (32)
//   NUM_WORDS : words per packed block (64)
//   BLOCK_W   : packed block width (2048)
//   CNT_W     : width of the word counter (6)
//   word_t, block_t, pack_state_t : common types
package sha_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 64;
   localparam int BLOCK_W   = WORD_W * NUM_WORDS;
   localparam int CNT_W     = 6;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [BLOCK_W-1:0] block_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } pack_state_t;

endpackage

// File: rtl/k_word_counter.sv
// Modulo-64 word counter for the block packer.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   inc      : count one accepted word
//   clr      : synchronous clear, wins over inc
//   count    : words counted so far (0..63)
//   terminal : this increment is the 64th word (count==63 & inc)
module k_word_counter
   import sha_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc) begin
         // Natural 6-bit wrap: 63 -> 0 on the word that completes a block
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count    = count_reg;
   assign terminal = inc && (count_reg == {CNT_W{1'b1}});

endmodule

// File: rtl/k_block_packer.sv
// Packs a valid/ready stream of 64 32-bit words into one 2048-bit block.
// Word i ends up at bits [2047-32*i -: 32] (first word in the MSBs).
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset
//   clear       : synchronous abort, discards partial or full block
//   in_valid    : in_word valid
//   in_word     : next word in write order
//   in_ready    : word accepted this cycle when in_valid is high
//   block_valid : block_out holds a complete block
//   block_ready : consumer takes the block this cycle
//   block_out   : packed block
//   word_count  : words accepted into the current block
module k_block_packer
   import sha_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WORD_W-1:0] in_word,
   output logic             in_ready,
   output logic             block_valid,
   input  logic             block_ready,
   output logic [BLOCK_W-1:0] block_out,
   output logic [CNT_W-1:0] word_count
);

   pack_state_t state_reg;
   block_t      block_reg;
   logic        in_ready_reg;
   logic        block_valid_reg;
   logic        accept;
   logic        last_word;

   // in_ready_reg is low in FULL and right after reset, so it alone gates
   // acceptance; clear drops any word offered alongside it.
   assign accept = (state_reg == FILL) && in_valid && in_ready_reg && !clear;

   k_word_counter u_counter (
      .clk      (clk),
      .reset    (reset),
      .inc      (accept),
      .clr      (clear),
      .count    (word_count),
      .terminal (last_word)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= FILL;
         block_reg       <= '0;
         in_ready_reg    <= 1'b0;
         block_valid_reg <= 1'b0;
      end else if (clear) begin
         state_reg       <= FILL;
         block_reg       <= '0;
         in_ready_reg    <= 1'b1;
         block_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            FILL: begin
               // Raises in_ready on the first edge after reset release
               in_ready_reg    <= 1'b1;
               block_valid_reg <= 1'b0;
               if (accept) begin
                  block_reg <= {block_reg[BLOCK_W-WORD_W-1:0], in_word};
                  if (last_word) begin
                     state_reg       <= FULL;
                     in_ready_reg    <= 1'b0;
                     block_valid_reg <= 1'b1;
                  end
               end
            end
            FULL: begin
               // Block register is left as-is; the next fill shifts it out
               if (block_ready) begin
                  state_reg       <= FILL;
                  in_ready_reg    <= 1'b1;
                  block_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg <= FILL;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_reg;
   assign block_valid = block_valid_reg;
   assign block_out   = block_reg;

endmodule

// File: tb/tb_k_block_packer.sv
// Self-checking bench for k_block_packer: a short vector table, directed
// multi-cycle sequences and randomized fills against a word-list model.
module tb_k_block_packer;
   import sha_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   word_t       in_word = '0;
   logic        in_ready;
   logic        block_valid;
   logic        block_ready = 1'b0;
   block_t      block_out;
   logic [5:0]  word_count;

   always #5 clk = ~clk;

   k_block_packer dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_word     (in_word),
      .in_ready    (in_ready),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .block_out   (block_out),
      .word_count  (word_count)
   );

   int checks = 0;
   int passed = 0;

   // ---------------- reference model ----------------
   // The packed view is "the tail of whatever block was there before,
   // followed by the words accepted since", seen as a list of 64 words.
   word_t m_prev[64];
   word_t m_q[$];
   bit    m_full;
   bit    m_ready;

   word_t exp_words[64];
   word_t k_const[64];

   function automatic block_t words_to_block(input word_t ws[64]);
      block_t b;
      b = '0;
      for (int j = 0; j < 64; j++) b[2047-32*j -: 32] = ws[j];
      return b;
   endfunction

   function automatic block_t m_view();
      word_t ws[64];
      int n;
      n = m_q.size();
      for (int j = 0; j < 64; j++) begin
         if (j < 64 - n) ws[j] = m_prev[j+n];
         else            ws[j] = m_q[j-(64-n)];
      end
      return words_to_block(ws);
   endfunction

   task automatic model_reset();
      for (int j = 0; j < 64; j++) m_prev[j] = '0;
      m_q.delete();
      m_full  = 1'b0;
      m_ready = 1'b0;
   endtask

   // Applies the current inputs to the model for one clock edge
   task automatic model_edge();
      if (clear) begin
         for (int j = 0; j < 64; j++) m_prev[j] = '0;
         m_q.delete();
         m_full  = 1'b0;
         m_ready = 1'b1;
      end else if (!m_full) begin
         if (in_valid && m_ready) begin
            m_q.push_back(in_word);
            if (m_q.size() == 64) begin
               for (int j = 0; j < 64; j++) m_prev[j] = m_q[j];
               m_q.delete();
               m_full  = 1'b1;
               m_ready = 1'b0;
            end else begin
               m_ready = 1'b1;
            end
         end else begin
            m_ready = 1'b1;
         end
      end else if (block_ready) begin
         m_full  = 1'b0;
         m_ready = 1'b1;
      end
   endtask

   // ---------------- comparison helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic check_block(input string name, input block_t act, input block_t exp);
      checks++;
      if (act === exp) passed++;
      else begin
         for (int j = 0; j < 64; j++) begin
            if (act[2047-32*j -: 32] !== exp[2047-32*j -: 32]) begin
               $display("FAIL %s: word %0d got %08h, expected %08h", name, j,
                        act[2047-32*j -: 32], exp[2047-32*j -: 32]);
               break;
            end
         end
      end
   endtask

   task automatic model_checks(input string tag);
      check({tag, ".in_ready"},    64'(in_ready),    64'(m_ready));
      check({tag, ".block_valid"}, 64'(block_valid), 64'(m_full));
      check({tag, ".word_count"},  64'(word_count),  64'(m_q.size()));
      check_block({tag, ".block_out"}, block_out, m_view());
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      model_checks(tag);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      model_reset();
      model_checks("reset_async");
      @(posedge clk);
      #1;
      model_checks("reset_held");
      reset = 1'b0;
   endtask

   task automatic push_block_b2b(input string tag);
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         in_word  = exp_words[i];
         tick(tag);
      end
      in_valid = 1'b0;
   endtask

   task automatic release_block();
      block_ready = 1'b1;
      tick("release");
      block_ready = 1'b0;
   endtask

   task automatic push_block_random(input string tag);
      int acc;
      int cyc;
      acc = 0;
      cyc = 0;
      while (acc < 64 && cyc < 1000) begin
         in_valid = ($urandom % 2) == 0;
         in_word  = in_valid ? exp_words[acc] : word_t'($urandom);
         if (in_valid && m_ready && !m_full) acc++;
         tick(tag);
         cyc++;
      end
      in_valid = 1'b0;
      check({tag, ".accepts_in_budget"}, 64'(acc), 64'd64);
      check({tag, ".block_valid_end"}, 64'(block_valid), 64'd1);
      check_block({tag, ".block_end"}, block_out, words_to_block(exp_words));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       v;
      word_t      w;
      logic       clr;
      logic       br;
      logic       e_ready;
      logic       e_valid;
      logic [5:0] e_cnt;
   } vec_t;

   vec_t tbl[8];

   initial begin
      block_t kblock;
      word_t  w;

      k_const = '{
         32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
         32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
         32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
         32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
         32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
         32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
         32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
         32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

      //        v     w             clr   br    ready valid cnt
      tbl[0] = '{1'b1, 32'h00000011, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}; // in_ready still low
      tbl[1] = '{1'b1, 32'h00000011, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
      tbl[2] = '{1'b0, 32'h00000099, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
      tbl[3] = '{1'b1, 32'h00000022, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2}; // block_ready ignored
      tbl[4] = '{1'b1, 32'h00000033, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0}; // word dropped by clear
      tbl[5] = '{1'b1, 32'h00000044, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
      tbl[6] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
      tbl[7] = '{1'b1, 32'h00000055, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1};

      apply_reset();

      for (int r = 0; r < 8; r++) begin
         in_valid    = tbl[r].v;
         in_word     = tbl[r].w;
         clear       = tbl[r].clr;
         block_ready = tbl[r].br;
         tick($sformatf("tbl%0d", r));
         check($sformatf("tbl%0d.in_ready", r),    64'(in_ready),    64'(tbl[r].e_ready));
         check($sformatf("tbl%0d.block_valid", r), 64'(block_valid), 64'(tbl[r].e_valid));
         check($sformatf("tbl%0d.word_count", r),  64'(word_count),  64'(tbl[r].e_cnt));
      end
      in_valid = 1'b0; clear = 1'b0; block_ready = 1'b0;
      $display("table vectors applied: %0d", 8);

      // Back-to-back ramp, word[i] = i+1
      clear = 1'b1; tick("clr0"); clear = 1'b0;
      for (int i = 0; i < 64; i++) exp_words[i] = word_t'(i + 1);
      push_block_b2b("ramp");
      check("ramp.block_valid", 64'(block_valid), 64'd1);
      check("ramp.msb_word", 64'(block_out[2047:2016]), 64'h00000001);
      check("ramp.lsb_word", 64'(block_out[31:0]), 64'h00000040);
      check("ramp.word_count", 64'(word_count), 64'd0);
      $display("ramp block: msb=%08h lsb=%08h", block_out[2047:2016], block_out[31:0]);
      release_block();

      // SHA-256 K constants
      for (int i = 0; i < 64; i++) exp_words[i] = k_const[i];
      kblock = words_to_block(exp_words);
      push_block_b2b("kconst");
      check("kconst.msb_word", 64'(block_out[2047:2016]), 64'h428a2f98);
      check("kconst.lsb_word", 64'(block_out[31:0]), 64'hc67178f2);
      w = block_out[2047-32*1 -: 32];
      check("kconst.extract_count1", 64'(w), 64'h71374491);
      $display("kconst block: msb=%08h lsb=%08h word1=%08h", block_out[2047:2016], block_out[31:0], w);

      // Hold FULL while upstream keeps offering a word
      in_valid = 1'b1; in_word = 32'hDEADBEEF; block_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick("hold");
         check_block("hold.block_out", block_out, kblock);
         check("hold.in_ready", 64'(in_ready), 64'd0);
         check("hold.word_count", 64'(word_count), 64'd0);
      end
      in_valid = 1'b0; block_ready = 1'b1;
      tick("hold_release");
      block_ready = 1'b0;
      check("hold_release.in_ready", 64'(in_ready), 64'd1);
      check("hold_release.block_valid", 64'(block_valid), 64'd0);
      $display("hold in FULL for 10 cycles, then released");

      // Randomized gaps across whole blocks
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 64; i++) exp_words[i] = word_t'($urandom);
         push_block_random($sformatf("rand%0d", b));
         $display("random block %0d: msb=%08h lsb=%08h", b, block_out[2047:2016], block_out[31:0]);
         release_block();
      end

      // Abort after 17 words
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1; in_word = word_t'($urandom); tick("abort_pre");
      end
      check("abort_pre.word_count", 64'(word_count), 64'd17);
      clear = 1'b1; in_valid = 1'b1; in_word = 32'hAAAAAAAA;
      tick("abort_clr");
      clear = 1'b0; in_valid = 1'b0;
      check("abort.word_count", 64'(word_count), 64'd0);
      check_block("abort.block_zero", block_out, '0);
      for (int i = 0; i < 64; i++) exp_words[i] = word_t'(32'h5000_0000 + i);
      push_block_b2b("abort_post");
      check_block("abort_post.block", block_out, words_to_block(exp_words));
      $display("abort after 17 words, fresh block msb=%08h", block_out[2047:2016]);
      release_block();

      // Async reset while FULL
      for (int i = 0; i < 64; i++) exp_words[i] = word_t'($urandom);
      push_block_b2b("pre_reset");
      check("pre_reset.block_valid", 64'(block_valid), 64'd1);
      apply_reset();
      check("areset.block_valid", 64'(block_valid), 64'd0);
      check("areset.in_ready", 64'(in_ready), 64'd0);
      tick("post_reset");
      check("post_reset.in_ready", 64'(in_ready), 64'd1);
      $display("async reset in FULL, in_ready=%0d after release", in_ready);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/k_block_packer.md
Name: k_block_packer

Overview:
Assembles a stream of 64 32-bit words into one 2048-bit packed block for the SHA-256 datapath. It is the writer for the packed-constant word extractor.
- Word i lands at bits [2047-32*i -: 32]: word 0 is MSB-aligned, so extracting at count=i returns the word written i-th.
- Input side is a valid/ready word stream; output side is a valid/ready block handshake.
- Sits between constant/message loaders and the block consumers.

Parameters:
WORD_W, 32, width of one word
NUM_WORDS, 64, words per block
BLOCK_W, WORD_W*NUM_WORDS (2048), packed block width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous abort; discards the partial or full block
in_valid  input  1  in_word is valid this cycle
in_word  input  WORD_W  next word, in write order
in_ready  output  1  packer accepts a word this cycle
block_valid  output  1  block_out holds a complete block
block_ready  input  1  consumer takes the block this cycle
block_out  output  BLOCK_W  packed block, word 0 in MSBs
word_count  output  6  words accepted into the current block (0..63)

Behaviour:
- States: FILL and FULL. Reset values:
  - state=FILL
  - internal block register=0
  - word_count=0
  - block_valid=0
  - in_ready is registered and resets to 0; it rises to 1 on the first clock after reset deasserts.
- FILL:
  - in_ready=1, block_valid=0.
  - On accept (in_valid & in_ready): block <= {block[BLOCK_W-WORD_W-1:0], in_word}; word_count increments.
  - Accept while word_count==63: shift still occurs, word_count wraps to 0, state -> FULL, in_ready->0 and block_valid->1 at the next edge.
  - No accept: all registers hold.
- FULL:
  - block_valid=1, in_ready=0; block_out is stable and equals the internal register.
  - in_valid is ignored and upstream must hold its word.
  - On block_ready: state -> FILL, block_valid->0, in_ready->1 next cycle. The block register is not zeroed; it is overwritten by shifting.
  - There is a one-cycle bubble between block handoff and the first word of the next block. There is no same-cycle pass-through.
- Latency: the 64th accepted word appears in block_out with block_valid=1 on the following cycle.
- clear has priority over every handshake:
  - Next state is FILL with word_count=0, block register=0, block_valid=0, in_ready=1.
  - A word presented in the same cycle as clear is dropped.
  - A block offered in the same cycle as clear counts as not transferred, even if block_ready=1.
- Async reset mid-block: everything returns to reset values immediately and the partial block is lost.
- block_ready while in FILL: ignored. in_valid while in FULL: ignored; no overflow is possible.
- Arithmetic:
  - word_count is 6-bit modulo-64; the wrap from 63 to 0 is legal only on the FILL->FULL transition.
  - No other width extension is performed.

Decomposition:
- Shared package sha_pkg holds:
  - WORD_W, NUM_WORDS, BLOCK_W
  - typedef word_t (logic [31:0])
  - typedef block_t (logic [2047:0])
  - enum pack_state_t {FILL, FULL}
- One natural sub-module, k_word_counter: 6-bit up-counter with inc, clr and terminal flag (count==63 & inc), asynchronous active-high reset.
- The shift register and FSM stay in k_block_packer.

Test Plan:
- Reset, then push words 0..63 with word[i]=i+1 back-to-back:
  - After the 64th, block_valid=1 one cycle later.
  - block_out[2047:2016]=0x00000001 and block_out[31:0]=0x00000040.
  - word_count=0.
- Push the SHA-256 K constants 0x428a2f98, 0x71374491, ..., 0xc67178f2:
  - block_out[2047:2016]=0x428a2f98 and block_out[31:0]=0xc67178f2.
  - A paired extractor at count=1 returns 0x71374491.
- Hold block_ready=0 for 10 cycles in FULL while in_valid=1 with 0xDEADBEEF:
  - block_out stays unchanged, in_ready=0, word_count=0.
  - After block_ready=1: in_ready=1 on the next cycle.
- Random in_valid gaps (50% duty) across a full block: result is identical to the back-to-back case and word_count tracks accepts only.
- After 17 words, assert clear with in_valid=1 and word 0xAAAAAAAA: word_count=0, block register=0, and 64 more words produce a block free of the aborted words.
- Assert async reset mid-FULL: block_valid drops to 0 without a clock edge, in_ready=0 while reset is held, and in_ready=1 one clock after release.
